traffic_intersection_ctrl: RTL and testbench

- Parametrised successor to the fixed 8-lane, 4-mode light breadboard: one sequential controller for an N-lane intersection.
- Modes: day (demand-driven round robin), night (flashing amber), pedestrian (all-red walk) and emergency (pre-emptive green), with proper yellow and all-red clearance phases.
- Counts on a 1 Hz tick enable from the system clock domain and drives the per-lane light outputs for the top level.

---
 rtl/traffic_intersection_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// N-lane intersection light controller: demand-driven day cycle, flashing night mode,
// pedestrian all-red walk and pre-emptive emergency green, all timed on a 1 Hz tick enable.
module traffic_intersection_ctrl #(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TMR_W       = 7,
    parameter int unsigned MIN_GREEN   = 5,
    parameter int unsigned MAX_GREEN   = 60,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned PED_TIME    = 20,
    parameter int unsigned EMG_TIME    = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          time_signal,
    input  logic                          ped_request,
    input  logic                          emg_request,
    input  logic [$clog2(NUM_LANES)-1:0]  emg_lane,
    input  logic [NUM_LANES*CNT_W-1:0]    lane_count,
    output logic [NUM_LANES-1:0]          green,
    output logic [NUM_LANES-1:0]          yellow,
    output logic [NUM_LANES-1:0]          red,
    output logic                          walk,
    output logic [1:0]                    mode,
    output logic [TMR_W-1:0]              time_left
);

    localparam int unsigned LW = $clog2(NUM_LANES);

    localparam logic [TMR_W-1:0] YellowLoad = TMR_W'(YELLOW_TIME - 1);
    localparam logic [TMR_W-1:0] AllRedLoad = TMR_W'(ALLRED_TIME - 1);
    localparam logic [TMR_W-1:0] PedLoad    = TMR_W'(PED_TIME - 1);
    localparam logic [TMR_W-1:0] EmgLoad    = TMR_W'(EMG_TIME - 1);

    localparam logic [1:0] ModeDay   = 2'd0;
    localparam logic [1:0] ModeNight = 2'd1;
    localparam logic [1:0] ModePed   = 2'd2;
    localparam logic [1:0] ModeEmg   = 2'd3;

    typedef enum logic [2:0] {
        StAllRed,
        StGreen,
        StYellow,
        StWalk,
        StEmg,
        StNight
    } state_e;

    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [LW-1:0]        cur_lane_q, cur_lane_d;
    logic                 ped_pending_q, ped_pending_d;
    logic                 flash_q, flash_d;
    logic [1:0]           mode_q, mode_d;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic [NUM_LANES-1:0] yellow_q, yellow_d;
    logic [NUM_LANES-1:0] red_q, red_d;
    logic                 walk_q, walk_d;

    logic [CNT_W-1:0]     lane_cnt [NUM_LANES];
    logic                 emg_valid;
    logic                 ped_now;
    logic                 timer_done;
    logic [LW-1:0]        next_lane;
    logic [31:0]          cand;
    logic [31:0]          sel_cnt;
    logic [31:0]          green_dur;
    logic [TMR_W-1:0]     green_load;
    logic [NUM_LANES-1:0] lane_oh;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
        assign lane_cnt[g] = lane_count[g*CNT_W +: CNT_W];
    end

    // A press on the deciding cycle already counts as pending.
    assign emg_valid  = emg_request && (32'(emg_lane) < NUM_LANES);
    assign ped_now    = ped_pending_q | ped_request;
    assign timer_done = (timer_q == '0);

    // Nearest demanding lane after cur_lane wins; the lowest offset is assigned last.
    always_comb begin
        next_lane = LW'((32'(cur_lane_q) + 32'd1) % NUM_LANES);
        cand      = '0;
        for (int i = NUM_LANES; i > 0; i--) begin
            cand = (32'(cur_lane_q) + 32'(i)) % NUM_LANES;
            if (lane_cnt[LW'(cand)] != '0) begin
                next_lane = LW'(cand);
            end
        end
    end

    always_comb begin
        sel_cnt = 32'(lane_cnt[next_lane]);
        if (sel_cnt < MIN_GREEN) begin
            green_dur = MIN_GREEN;
        end else if (sel_cnt > MAX_GREEN) begin
            green_dur = MAX_GREEN;
        end else begin
            green_dur = sel_cnt;
        end
        green_load = TMR_W'(green_dur - 32'd1);
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cur_lane_d    = cur_lane_q;
        ped_pending_d = ped_now;
        flash_d       = flash_q;
        mode_d        = mode_q;

        case (state_q)
            StAllRed: begin
                if (tick) begin
                    if (timer_done) begin
                        if (emg_valid) begin
                            state_d    = StEmg;
                            cur_lane_d = emg_lane;
                            timer_d    = EmgLoad;
                            mode_d     = ModeEmg;
                        end else if (ped_now) begin
                            state_d       = StWalk;
                            timer_d       = PedLoad;
                            ped_pending_d = 1'b0;
                            mode_d        = ModePed;
                        end else if (time_signal) begin
                            state_d = StNight;
                            timer_d = '0;
                            flash_d = 1'b1;
                            mode_d  = ModeNight;
                        end else begin
                            state_d    = StGreen;
                            cur_lane_d = next_lane;
                            timer_d    = green_load;
                            mode_d     = ModeDay;
                        end
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            StGreen: begin
                if (emg_valid) begin
                    if (emg_lane == cur_lane_q) begin
                        state_d = StEmg;
                        timer_d = EmgLoad;
                        mode_d  = ModeEmg;
                    end else begin
                        state_d = StYellow;
                        timer_d = YellowLoad;
                    end
                end else if (tick) begin
                    if (timer_done) begin
                        state_d = StYellow;
                        timer_d = YellowLoad;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            StYellow: begin
                if (tick) begin
                    if (timer_done) begin
                        state_d = StAllRed;
                        timer_d = AllRedLoad;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            StWalk: begin
                if (emg_valid) begin
                    state_d = StAllRed;
                    timer_d = AllRedLoad;
                end else if (tick) begin
                    if (timer_done) begin
                        state_d = StAllRed;
                        timer_d = AllRedLoad;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            StEmg: begin
                // The hold keys off the raw request level, not the latched lane.
                if (emg_request) begin
                    timer_d = EmgLoad;
                end else if (tick) begin
                    if (timer_done) begin
                        state_d = StYellow;
                        timer_d = YellowLoad;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            StNight: begin
                if (!time_signal || ped_now || emg_valid) begin
                    state_d = StAllRed;
                    timer_d = AllRedLoad;
                end else if (tick) begin
                    flash_d = ~flash_q;
                end
            end
            default: begin
                state_d = StAllRed;
                timer_d = AllRedLoad;
            end
        endcase
    end

    // Lights are decoded from the next state so every output leaves a flop.
    always_comb begin
        lane_oh  = NUM_LANES'(1) << cur_lane_d;
        green_d  = '0;
        yellow_d = '0;
        red_d    = '1;
        walk_d   = 1'b0;
        case (state_d)
            StGreen, StEmg: begin
                green_d = lane_oh;
                red_d   = ~lane_oh;
            end
            StYellow: begin
                yellow_d = lane_oh;
                red_d    = ~lane_oh;
            end
            StWalk: begin
                walk_d = 1'b1;
            end
            StNight: begin
                red_d    = '0;
                yellow_d = {NUM_LANES{flash_d}};
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StAllRed;
            timer_q       <= AllRedLoad;
            cur_lane_q    <= LW'(NUM_LANES - 1);
            ped_pending_q <= 1'b0;
            flash_q       <= 1'b0;
            mode_q        <= ModeDay;
            green_q       <= '0;
            yellow_q      <= '0;
            red_q         <= '1;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cur_lane_q    <= cur_lane_d;
            ped_pending_q <= ped_pending_d;
            flash_q       <= flash_d;
            mode_q        <= mode_d;
            green_q       <= green_d;
            yellow_q      <= yellow_d;
            red_q         <= red_d;
            walk_q        <= walk_d;
        end
    end

    assign green     = green_q;
    assign yellow    = yellow_q;
    assign red       = red_q;
    assign walk      = walk_q;
    assign mode      = mode_q;
    assign time_left = timer_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl with 5 lanes: a phase table for the
// day/night cycle plus hand-written emergency, pedestrian and reset sequences.
module tb_traffic_intersection_ctrl;

    localparam int NL = 5;
    localparam int CA = 0;  // all red
    localparam int CG = 1;  // green (day or emergency)
    localparam int CY = 2;  // yellow
    localparam int CW = 3;  // walk
    localparam int CN = 4;  // night flash

    logic            clk;
    logic            rst;
    logic            tick;
    logic            time_signal;
    logic            ped_request;
    logic            emg_request;
    logic [2:0]      emg_lane;
    logic [NL*8-1:0] lane_count;
    logic [NL-1:0]   green;
    logic [NL-1:0]   yellow;
    logic [NL-1:0]   red;
    logic            walk;
    logic [1:0]      mode;
    logic [6:0]      time_left;

    traffic_intersection_ctrl #(
        .NUM_LANES (NL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .time_signal (time_signal),
        .ped_request (ped_request),
        .emg_request (emg_request),
        .emg_lane    (emg_lane),
        .lane_count  (lane_count),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .walk        (walk),
        .mode        (mode),
        .time_left   (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0] g;
        logic [NL-1:0] y;
        logic [NL-1:0] r;
        logic          w;
        logic [1:0]    m;
        logic [6:0]    tl;
    } exp_t;

    typedef struct {
        int            col;
        int            lane;
        logic [1:0]    m;
        int            n;
        logic [NL*8-1:0] cnt;
        logic          ts;
        logic          emg;
        logic [2:0]    el;
    } rec_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    rec_t  tbl[30];

    function automatic exp_t mk(input int col, input int lane, input logic [1:0] m,
                                input int tl, input logic fl);
        exp_t e;
        e.g  = '0;
        e.y  = '0;
        e.r  = '1;
        e.w  = 1'b0;
        e.m  = m;
        e.tl = 7'(tl);
        case (col)
            CG: begin e.g[lane] = 1'b1; e.r[lane] = 1'b0; end
            CY: begin e.y[lane] = 1'b1; e.r[lane] = 1'b0; end
            CW: e.w = 1'b1;
            CN: begin e.r = '0; e.y = {NL{fl}}; end
            default: e.r = '1;
        endcase
        return e;
    endfunction

    function automatic rec_t rec(input int col, input int lane, input logic [1:0] m,
                                 input int n, input logic [NL*8-1:0] cnt, input logic ts,
                                 input logic emg, input logic [2:0] el);
        rec_t t;
        t.col = col; t.lane = lane; t.m = m; t.n = n;
        t.cnt = cnt; t.ts = ts; t.emg = emg; t.el = el;
        return t;
    endfunction

    task automatic check();
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_vec++;
        if (green !== e.g || yellow !== e.y || red !== e.r || walk !== e.w ||
            mode !== e.m || time_left !== e.tl) begin
            n_err++;
            $display("FAIL %s: got g=%b y=%b r=%b walk=%b mode=%0d tl=%0d, want g=%b y=%b r=%b walk=%b mode=%0d tl=%0d",
                     nm, green, yellow, red, walk, mode, time_left,
                     e.g, e.y, e.r, e.w, e.m, e.tl);
        end
    endtask

    task automatic step(input logic t, input exp_t e, input string nm);
        tick = t;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        check();
    endtask

    // One tick per cycle, time_left counting down from tl_hi.
    task automatic seq(input int col, input int lane, input logic [1:0] m, input int tl_hi,
                       input int cnt, input string nm);
        for (int k = 0; k < cnt; k++) begin
            step(1'b1, mk(col, lane, m, tl_hi - k, 1'b0), $sformatf("%s.%0d", nm, k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*8-1:0] c1;
        logic [NL*8-1:0] c0;
        c1 = {8'd0, 8'd70, 8'd0, 8'd7, 8'd0};
        c0 = '0;

        tbl[0]  = rec(CA, 0, 2'd0, 1,  c1, 1'b0, 1'b0, 3'd0);
        tbl[1]  = rec(CG, 1, 2'd0, 7,  c1, 1'b0, 1'b0, 3'd0);
        tbl[2]  = rec(CY, 1, 2'd0, 3,  c1, 1'b0, 1'b0, 3'd0);
        tbl[3]  = rec(CA, 0, 2'd0, 2,  c1, 1'b0, 1'b0, 3'd0);
        tbl[4]  = rec(CG, 3, 2'd0, 60, c1, 1'b0, 1'b0, 3'd0);
        tbl[5]  = rec(CY, 3, 2'd0, 3,  c1, 1'b0, 1'b0, 3'd0);
        tbl[6]  = rec(CA, 0, 2'd0, 2,  c1, 1'b0, 1'b0, 3'd0);
        tbl[7]  = rec(CG, 1, 2'd0, 7,  c1, 1'b0, 1'b0, 3'd0);
        tbl[8]  = rec(CY, 1, 2'd0, 3,  c1, 1'b0, 1'b0, 3'd0);
        tbl[9]  = rec(CA, 0, 2'd0, 2,  c1, 1'b0, 1'b0, 3'd0);
        tbl[10] = rec(CG, 2, 2'd0, 5,  c0, 1'b0, 1'b0, 3'd0);
        tbl[11] = rec(CY, 2, 2'd0, 3,  c0, 1'b0, 1'b0, 3'd0);
        tbl[12] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b0, 3'd0);
        tbl[13] = rec(CG, 3, 2'd0, 5,  c0, 1'b0, 1'b0, 3'd0);
        tbl[14] = rec(CY, 3, 2'd0, 3,  c0, 1'b0, 1'b0, 3'd0);
        tbl[15] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b0, 3'd0);
        tbl[16] = rec(CG, 4, 2'd0, 5,  c0, 1'b0, 1'b0, 3'd0);
        tbl[17] = rec(CY, 4, 2'd0, 3,  c0, 1'b0, 1'b0, 3'd0);
        tbl[18] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b0, 3'd0);
        tbl[19] = rec(CG, 0, 2'd0, 5,  c0, 1'b0, 1'b0, 3'd0);
        tbl[20] = rec(CY, 0, 2'd0, 3,  c0, 1'b0, 1'b0, 3'd0);
        tbl[21] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b0, 3'd0);
        tbl[22] = rec(CN, 0, 2'd1, 4,  c0, 1'b1, 1'b0, 3'd0);
        tbl[23] = rec(CA, 0, 2'd1, 2,  c0, 1'b0, 1'b0, 3'd0);
        tbl[24] = rec(CG, 1, 2'd0, 5,  c0, 1'b0, 1'b0, 3'd0);
        tbl[25] = rec(CY, 1, 2'd0, 3,  c0, 1'b0, 1'b0, 3'd0);
        tbl[26] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b1, 3'd5);
        tbl[27] = rec(CG, 2, 2'd0, 5,  c0, 1'b0, 1'b1, 3'd5);
        tbl[28] = rec(CY, 2, 2'd0, 3,  c0, 1'b0, 1'b1, 3'd5);
        tbl[29] = rec(CA, 0, 2'd0, 2,  c0, 1'b0, 1'b0, 3'd0);

        rst         = 1'b1;
        tick        = 1'b0;
        time_signal = 1'b0;
        ped_request = 1'b0;
        emg_request = 1'b0;
        emg_lane    = 3'd0;
        lane_count  = c1;
        @(posedge clk);
        #1;
        step(1'b1, mk(CA, 0, 2'd0, 1, 1'b0), "reset");
        rst = 1'b0;
        step(1'b0, mk(CA, 0, 2'd0, 1, 1'b0), "no_tick_hold");

        for (int i = 0; i < 30; i++) begin
            lane_count  = tbl[i].cnt;
            time_signal = tbl[i].ts;
            emg_request = tbl[i].emg;
            emg_lane    = tbl[i].el;
            for (int k = 0; k < tbl[i].n; k++) begin
                step(1'b1,
                     mk(tbl[i].col, tbl[i].lane, tbl[i].m,
                        (tbl[i].col == CN) ? 0 : tbl[i].n - 1 - k,
                        (tbl[i].col == CN) ? ((k % 2) == 0) : 1'b0),
                     $sformatf("tbl%0d.%0d", i, k));
            end
        end

        // Emergency on another lane cuts green; hold, countdown and reload.
        seq(CG, 3, 2'd0, 4, 3, "A.green");
        emg_request = 1'b1;
        emg_lane    = 3'd1;
        step(1'b0, mk(CY, 3, 2'd0, 2, 1'b0), "A.preempt");
        seq(CY, 3, 2'd0, 1, 2, "A.yellow");
        seq(CA, 0, 2'd0, 1, 2, "A.allred");
        step(1'b1, mk(CG, 1, 2'd3, 9, 1'b0), "A.emg_entry");
        emg_lane = 3'd4;
        seq(CG, 1, 2'd3, 9, 1, "A.hold0");
        seq(CG, 1, 2'd3, 9, 1, "A.hold1");
        seq(CG, 1, 2'd3, 9, 1, "A.hold2");
        emg_request = 1'b0;
        seq(CG, 1, 2'd3, 8, 3, "A.count");
        emg_request = 1'b1;
        step(1'b1, mk(CG, 1, 2'd3, 9, 1'b0), "A.reload");
        emg_request = 1'b0;
        seq(CG, 1, 2'd3, 8, 9, "A.count2");
        seq(CY, 1, 2'd3, 2, 3, "A.emg_yellow");
        seq(CA, 0, 2'd3, 1, 2, "A.emg_allred");

        // Pedestrian pulse mid-green is served after the clearance.
        step(1'b1, mk(CG, 2, 2'd0, 4, 1'b0), "B.green");
        ped_request = 1'b1;
        step(1'b0, mk(CG, 2, 2'd0, 4, 1'b0), "B.ped_pulse");
        ped_request = 1'b0;
        seq(CG, 2, 2'd0, 3, 4, "B.green_rest");
        seq(CY, 2, 2'd0, 2, 3, "B.yellow");
        seq(CA, 0, 2'd0, 1, 2, "B.allred");
        seq(CW, 0, 2'd2, 19, 20, "B.walk");
        seq(CA, 0, 2'd2, 1, 2, "B.allred2");
        step(1'b1, mk(CG, 3, 2'd0, 4, 1'b0), "B.green_after_walk");

        // Night entered only after green completes; a ped press exits it.
        time_signal = 1'b1;
        seq(CG, 3, 2'd0, 3, 4, "C.green");
        seq(CY, 3, 2'd0, 2, 3, "C.yellow");
        seq(CA, 0, 2'd0, 1, 2, "C.allred");
        step(1'b1, mk(CN, 0, 2'd1, 0, 1'b1), "C.night0");
        step(1'b1, mk(CN, 0, 2'd1, 0, 1'b0), "C.night1");
        step(1'b1, mk(CN, 0, 2'd1, 0, 1'b1), "C.night2");
        ped_request = 1'b1;
        step(1'b0, mk(CA, 0, 2'd1, 1, 1'b0), "C.night_exit");
        ped_request = 1'b0;
        step(1'b1, mk(CA, 0, 2'd1, 0, 1'b0), "C.allred");
        seq(CW, 0, 2'd2, 19, 3, "C.walk");
        rst         = 1'b1;
        emg_request = 1'b1;
        ped_request = 1'b1;
        emg_lane    = 3'd2;
        step(1'b1, mk(CA, 0, 2'd0, 1, 1'b0), "C.reset_mid_walk");
        rst         = 1'b0;
        emg_request = 1'b0;
        ped_request = 1'b0;
        time_signal = 1'b0;

        // Simultaneous ped and emergency; emergency aborts the later walk.
        ped_request = 1'b1;
        emg_request = 1'b1;
        emg_lane    = 3'd0;
        step(1'b1, mk(CA, 0, 2'd0, 0, 1'b0), "D.both");
        ped_request = 1'b0;
        step(1'b1, mk(CG, 0, 2'd3, 9, 1'b0), "D.emg_first");
        emg_request = 1'b0;
        seq(CG, 0, 2'd3, 8, 9, "D.count");
        seq(CY, 0, 2'd3, 2, 3, "D.yellow");
        seq(CA, 0, 2'd3, 1, 2, "D.allred");
        seq(CW, 0, 2'd2, 19, 3, "D.walk");
        emg_request = 1'b1;
        emg_lane    = 3'd3;
        step(1'b0, mk(CA, 0, 2'd2, 1, 1'b0), "D.walk_abort");
        seq(CA, 0, 2'd2, 0, 1, "D.allred_full");
        step(1'b1, mk(CG, 3, 2'd3, 9, 1'b0), "D.emg3");
        emg_request = 1'b0;
        seq(CG, 3, 2'd3, 8, 9, "D.count3");
        seq(CY, 3, 2'd3, 2, 3, "D.yellow3");
        seq(CA, 0, 2'd3, 1, 2, "D.allred3");
        step(1'b1, mk(CG, 4, 2'd0, 4, 1'b0), "D.no_walk");
        emg_request = 1'b1;
        emg_lane    = 3'd4;
        step(1'b0, mk(CG, 4, 2'd3, 9, 1'b0), "D.green_to_emg");
        emg_request = 1'b0;
        step(1'b1, mk(CG, 4, 2'd3, 8, 1'b0), "D.emg_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
